// File: rtl/micro_sequencer_pkg.sv
// Shared types and constants for the 4-bit computer's instruction sequencer.
// Widths are fixed by the control ROM and are not meant to be overridden.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC0 = 3'd2,
        EXEC1 = 3'd3,
        HALT  = 3'd4
    } seq_state_e;

    localparam int OPCODE_W   = 3;
    localparam int ROM_ADDR_W = 4;
    localparam int CTRL_W     = 10;
    localparam int INSTR_W    = 8;

    localparam logic [OPCODE_W-1:0] OP_ILLEGAL = 3'b101;

    // A control ROM row is addressed as {opcode, microstep}.
    function automatic logic [ROM_ADDR_W-1:0] rom_row(input logic [OPCODE_W-1:0] op,
                                                      input logic                stp);
        return {op, stp};
    endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Bundle of sequencer-facing signals: run control, program memory, control ROM and datapath.
// ctrl is meaningful only while ctrl_valid is high; there is no back-pressure (no ready).
interface micro_sequencer_if;
    import seq_pkg::*;

    logic                      run;
    logic                      step_req;
    logic                      halt_req;
    logic [3:0]                imem_addr;
    logic [INSTR_W-1:0]        imem_data;
    logic [ROM_ADDR_W-1:0]     rom_addr;
    logic [CTRL_W-1:0]         rom_data;
    logic [CTRL_W-1:0]         ctrl;
    logic                      ctrl_valid;
    logic [3:0]                imm;
    logic                      jmp_en;
    logic [3:0]                jmp_addr;
    logic [3:0]                pc;
    logic                      busy;
    logic                      halted;
    logic                      illegal;
    logic [2:0]                dbg_state;
    logic [INSTR_W-1:0]        dbg_ir;

    modport master (
        input  run, step_req, halt_req, imem_data, rom_data, jmp_en, jmp_addr,
        output imem_addr, rom_addr, ctrl, ctrl_valid, imm, pc, busy, halted, illegal,
               dbg_state, dbg_ir
    );

    modport slave (
        output run, step_req, halt_req, imem_data, rom_data, jmp_en, jmp_addr,
        input  imem_addr, rom_addr, ctrl, ctrl_valid, imm, pc, busy, halted, illegal,
               dbg_state, dbg_ir
    );

endinterface

// File: rtl/micro_sequencer_program_counter.sv
// 4-bit program counter; a jump load wins over the increment, which wraps modulo 16.
module program_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       inc_i,
    input  logic [3:0] load_val_i,
    output logic [3:0] pc_o
);

    logic [3:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= 4'd0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/micro_sequencer.sv
// Fetches instructions, walks each opcode through its two control ROM rows and
// gates the ROM word onto the datapath; owns the FSM, ir and the halt/illegal flags.
module micro_sequencer (
    input  logic               clk,
    input  logic               rst,
    micro_sequencer_if.master  bus
);
    import seq_pkg::*;

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_FETCH = FETCH;
    localparam logic [2:0] ST_EXEC0 = EXEC0;
    localparam logic [2:0] ST_EXEC1 = EXEC1;
    localparam logic [2:0] ST_HALT  = HALT;

    logic [2:0]            state_q, state_d;
    logic [INSTR_W-1:0]    ir_q, ir_d;
    logic [ROM_ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic                  halt_pend_q, halt_pend_d;
    logic                  illegal_q, illegal_d;
    logic                  pc_load, pc_inc;
    logic [3:0]            pc;
    logic [OPCODE_W-1:0]   fetch_op;
    logic                  busy, exec;

    assign fetch_op = bus.imem_data[7:5];
    assign busy     = (state_q == ST_FETCH) || (state_q == ST_EXEC0) || (state_q == ST_EXEC1);
    assign exec     = (state_q == ST_EXEC0) || (state_q == ST_EXEC1);

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        rom_addr_d = rom_addr_q;
        illegal_d  = illegal_q;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.halt_req || halt_pend_q) begin
                    state_d = ST_HALT;
                end else if (bus.run || bus.step_req) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ir_d = bus.imem_data;
                // Illegal opcode halts without touching pc so it still points at the culprit.
                if (fetch_op == OP_ILLEGAL) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    rom_addr_d = rom_row(fetch_op, 1'b0);
                    state_d    = ST_EXEC0;
                end
            end
            ST_EXEC0: begin
                rom_addr_d = rom_row(ir_q[7:5], 1'b1);
                state_d    = ST_EXEC1;
            end
            ST_EXEC1: begin
                pc_load    = bus.jmp_en;
                pc_inc     = !bus.jmp_en;
                rom_addr_d = '0;
                if (halt_pend_q || bus.halt_req) begin
                    state_d = ST_HALT;
                end else if (bus.run) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A halt request is remembered while an instruction is in flight and forgotten once honoured.
    always_comb begin
        halt_pend_d = halt_pend_q;
        if (state_d == ST_HALT && state_q != ST_HALT) begin
            halt_pend_d = 1'b0;
        end else if (busy && bus.halt_req) begin
            halt_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ir_q        <= '0;
            rom_addr_q  <= '0;
            halt_pend_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            rom_addr_q  <= rom_addr_d;
            halt_pend_q <= halt_pend_d;
            illegal_q   <= illegal_d;
        end
    end

    program_counter u_pc (
        .clk        (clk),
        .rst        (rst),
        .load_i     (pc_load),
        .inc_i      (pc_inc),
        .load_val_i (bus.jmp_addr),
        .pc_o       (pc)
    );

    assign bus.imem_addr  = pc;
    assign bus.pc         = pc;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.ctrl_valid = exec;
    assign bus.ctrl       = exec ? bus.rom_data : '0;
    assign bus.imm        = ir_q[3:0];
    assign bus.busy       = busy;
    assign bus.halted     = (state_q == ST_HALT);
    assign bus.illegal    = illegal_q;
    assign bus.dbg_state  = state_q;
    assign bus.dbg_ir     = ir_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed, table-driven bench for micro_sequencer with behavioural program memory and control ROM.
module tb_micro_sequencer;

    typedef struct {
        logic       do_rst;
        logic       run;
        logic       step;
        logic       halt;
        logic       jen;
        logic [3:0] jaddr;
        logic       busy;
        logic       valid;
        logic [3:0] rom;
        logic [3:0] pc;
        logic [3:0] imm;
        logic       halted;
        logic       illegal;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [7:0] imem [16];
    vec_t tbl [$];

    micro_sequencer_if bus ();

    micro_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every ROM row is distinct and non-zero so gating and addressing faults show up on ctrl.
    function automatic logic [9:0] rom_val(input logic [3:0] a);
        return {a, ~a, 2'b10};
    endfunction

    assign bus.imem_data = imem[bus.imem_addr];
    assign bus.rom_data  = rom_val(bus.rom_addr);

    function automatic vec_t mk(input logic do_rst, run, step, halt, jen, input logic [3:0] jaddr,
                                input logic busy, valid, input logic [3:0] rom, pc, imm,
                                input logic halted, illegal);
        vec_t v;
        v.do_rst = do_rst; v.run = run; v.step = step; v.halt = halt; v.jen = jen;
        v.jaddr = jaddr; v.busy = busy; v.valid = valid; v.rom = rom; v.pc = pc;
        v.imm = imm; v.halted = halted; v.illegal = illegal;
        return v;
    endfunction

    task automatic check_field(input string name, input int idx, input logic [15:0] act,
                               input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input vec_t v);
        logic [9:0] exp_ctrl;
        exp_ctrl = v.valid ? rom_val(v.rom) : 10'd0;
        check_field("busy",       idx, 16'(bus.busy),       16'(v.busy));
        check_field("ctrl_valid", idx, 16'(bus.ctrl_valid), 16'(v.valid));
        check_field("rom_addr",   idx, 16'(bus.rom_addr),   16'(v.rom));
        check_field("ctrl",       idx, 16'(bus.ctrl),       16'(exp_ctrl));
        check_field("pc",         idx, 16'(bus.pc),         16'(v.pc));
        check_field("imem_addr",  idx, 16'(bus.imem_addr),  16'(v.pc));
        check_field("imm",        idx, 16'(bus.imm),        16'(v.imm));
        check_field("halted",     idx, 16'(bus.halted),     16'(v.halted));
        check_field("illegal",    idx, 16'(bus.illegal),    16'(v.illegal));
    endtask

    task automatic drive(input logic run, step, halt, jen, input logic [3:0] jaddr);
        bus.run      = run;
        bus.step_req = step;
        bus.halt_req = halt;
        bus.jmp_en   = jen;
        bus.jmp_addr = jaddr;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 16; i++) imem[i] = 8'h00;
        imem[0]  = 8'h00;  imem[1] = 8'h40;  imem[2] = 8'hC0;  imem[3] = 8'h35;
        imem[4]  = 8'h6F;  imem[5] = 8'h5C;  imem[6] = 8'hA3;
        imem[10] = 8'hE9;  imem[15] = 8'h82;

        // Each row: inputs applied before an edge, outputs expected just after it.
        //               rst run stp hlt jen jad   bsy vld rom   pc    imm   hlt ill
        // Back-to-back run; run drops during the third instruction.
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0,  1, 0, 4'd0,  4'd0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0,  1, 1, 4'd0,  4'd0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0,  1, 1, 4'd1,  4'd0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0,  1, 0, 4'd0,  4'd1, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0,  1, 1, 4'd4,  4'd1, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0,  1, 1, 4'd5,  4'd1, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0,  1, 0, 4'd0,  4'd2, 4'h0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0,  1, 1, 4'd12, 4'd2, 4'h0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0,  1, 1, 4'd13, 4'd2, 4'h0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0,  0, 0, 4'd0,  4'd3, 4'h0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0,  0, 0, 4'd0,  4'd3, 4'h0, 0, 0));
        // Single step; a second step_req during EXEC0 is dropped.
        tbl.push_back(mk(0, 0, 1, 0, 0, 4'h0,  1, 0, 4'd0,  4'd3, 4'h0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0,  1, 1, 4'd2,  4'd3, 4'h5, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 4'h0,  1, 1, 4'd3,  4'd3, 4'h5, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0,  0, 0, 4'd0,  4'd4, 4'h5, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0,  0, 0, 4'd0,  4'd4, 4'h5, 0, 0));
        // Jumps: jmp_en outside EXEC1 is ignored; jump to A, then to F, then wrap to 0.
        tbl.push_back(mk(0, 0, 1, 0, 0, 4'h0,  1, 0, 4'd0,  4'd4, 4'h5, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 4'h3,  1, 1, 4'd6,  4'd4, 4'hF, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 4'h3,  1, 1, 4'd7,  4'd4, 4'hF, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 4'hA,  1, 0, 4'd0,  4'hA, 4'hF, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0,  1, 1, 4'd14, 4'hA, 4'h9, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0,  1, 1, 4'd15, 4'hA, 4'h9, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 4'hF,  1, 0, 4'd0,  4'hF, 4'h9, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0,  1, 1, 4'd8,  4'hF, 4'h2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0,  1, 1, 4'd9,  4'hF, 4'h2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'h0,  0, 0, 4'd0,  4'd0, 4'h2, 0, 0));
        // halt_req during EXEC0 under run: instruction finishes, then HALT for good.
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0,  1, 0, 4'd0,  4'd0, 4'h2, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0,  1, 1, 4'd0,  4'd0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 4'h0,  1, 1, 4'd1,  4'd0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0,  0, 0, 4'd0,  4'd1, 4'h0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 4'h0,  0, 0, 4'd0,  4'd1, 4'h0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0,  0, 0, 4'd0,  4'd1, 4'h0, 1, 0));
        // Reset, jump to 6, fetch illegal 0xA3: HALT with pc parked at 6.
        tbl.push_back(mk(1, 1, 0, 0, 0, 4'h0,  1, 0, 4'd0,  4'd0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0,  1, 1, 4'd0,  4'd0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0,  1, 1, 4'd1,  4'd0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 4'h6,  1, 0, 4'd0,  4'd6, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0,  0, 0, 4'd0,  4'd6, 4'h3, 1, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 4'h0,  0, 0, 4'd0,  4'd6, 4'h3, 1, 1));
        // Reset clears illegal; halt_req in IDLE goes straight to HALT.
        tbl.push_back(mk(1, 0, 0, 1, 0, 4'h0,  0, 0, 4'd0,  4'd0, 4'h0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 4'h0,  1, 0, 4'd0,  4'd0, 4'h0, 0, 0));
        // Walk into EXEC1 of the instruction at 5 before the asynchronous reset below.
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0,  1, 1, 4'd0,  4'd0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0,  1, 1, 4'd1,  4'd0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 4'h5,  1, 0, 4'd0,  4'd5, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0,  1, 1, 4'd4,  4'd5, 4'hC, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 4'h0,  1, 1, 4'd5,  4'd5, 4'hC, 0, 0));

        rst = 1'b1;
        drive(0, 0, 0, 0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        check_all(-1, mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 4'd0, 4'd0, 4'h0, 0, 0));
        rst = 1'b0;

        foreach (tbl[i]) begin
            if (tbl[i].do_rst) pulse_reset();
            drive(tbl[i].run, tbl[i].step, tbl[i].halt, tbl[i].jen, tbl[i].jaddr);
            @(posedge clk);
            #1;
            check_all(i, tbl[i]);
        end

        // Reset mid-EXEC1 must clear outputs without waiting for a clock edge.
        drive(1, 0, 0, 0, 4'h0);
        rst = 1'b1;
        #1;
        check_all(100, mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 4'd0, 4'd0, 4'h0, 0, 0));
        @(posedge clk);
        #1;
        check_all(101, mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 4'd0, 4'd0, 4'h0, 0, 0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all(102, mk(0, 1, 0, 0, 0, 4'h0, 1, 0, 4'd0, 4'd0, 4'h0, 0, 0));
        @(posedge clk);
        #1;
        check_all(103, mk(0, 1, 0, 0, 0, 4'h0, 1, 1, 4'd0, 4'd0, 4'h0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
